// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues ready-handshake fetches to
// instruction memory, and drives the IF/ID pipeline register. A one-entry
// skid buffer holds a response that lands while ID is stalled. Taken
// branches flush both the IF/ID register and the skid buffer.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_valid
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc_q, buf_pc_d;

  // Next-state logic: branch flush beats any memory response or stall.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    buf_d      = buf_q;
    buf_pc_d   = buf_pc_q;

    if (state_q != S_BOOT && branch_taken) begin
      // Skid buffer contents become dead once we leave S_HOLD; no need to clear.
      pc_d       = branch_target;
      state_d    = S_FETCH;
      id_valid_d = 1'b0;
      id_instr_d = 32'h0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_d = S_FETCH;
        end
        S_FETCH: begin
          if (imem_ready) begin
            pc_d = pc_q + PC_INC;
            if (!stall) begin
              id_instr_d = imem_rdata;
              id_pc_d    = pc_q;
              id_valid_d = 1'b1;
            end else begin
              buf_d    = imem_rdata;
              buf_pc_d = pc_q;
              state_d  = S_HOLD;
            end
          end else if (!stall) begin
            // Memory wait state with ID free: present a bubble.
            id_valid_d = 1'b0;
            id_instr_d = 32'h0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            id_instr_d = buf_q;
            id_pc_d    = buf_pc_q;
            id_valid_d = 1'b1;
            state_d    = S_FETCH;
          end
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      id_instr_q <= 32'h0;
      id_pc_q    <= 32'h0;
      id_valid_q <= 1'b0;
      buf_q      <= 32'h0;
      buf_pc_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      buf_q      <= buf_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

  // Outputs: request only while fetching; address is always the PC.
  always_comb begin
    imem_req  = (state_q == S_FETCH);
    imem_addr = pc_q;
    id_instr  = id_instr_q;
    id_pc     = id_pc_q;
    id_valid  = id_valid_q;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage. Memory returns 0x1000_0000+addr,
// so every valid IF/ID instruction is predictable from its PC.
module tb_if_stage;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .PC_INC  (32'd4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_valid     (id_valid)
  );

  always #5 clk = ~clk;

  // Simple memory model: word content derived from its address.
  assign imem_rdata = BASE + imem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected instruction: bubbles/NOPs are zero, valid words follow the memory model.
  task automatic add(input logic rst, input logic rdy, input logic stl, input logic br,
                     input logic [31:0] tgt, input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.stl = stl; v.br = br; v.tgt = tgt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    v.e_instr = e_valid ? (BASE + e_pc) : 32'h0;
    vecs.push_back(v);
  endtask

  task automatic step(input logic rst, input logic rdy, input logic stl, input logic br,
                      input logic [31:0] tgt);
    @(negedge clk);
    reset = rst; imem_ready = rdy; stall = stl; branch_taken = br; branch_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_pc);
    chk({tag, ".req"},   {31'h0, imem_req}, {31'h0, e_req});
    chk({tag, ".addr"},  imem_addr, e_addr);
    chk({tag, ".valid"}, {31'h0, id_valid}, {31'h0, e_valid});
    chk({tag, ".pc"},    id_pc, e_pc);
    chk({tag, ".instr"}, id_instr, e_valid ? (BASE + e_pc) : 32'h0);
  endtask

  initial begin
    int waited;
    reset = 1'b1; imem_ready = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0;

    //   rst rdy stl br  tgt            req addr           vld pc
    add(1, 1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0);   // reset
    add(1, 1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0);
    add(0, 1, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0);   // S_BOOT -> S_FETCH
    add(0, 1, 0, 0, 32'h0,          1, 32'h4,          1, 32'h0);   // first instr
    add(0, 1, 0, 0, 32'h0,          1, 32'h8,          1, 32'h4);
    add(0, 0, 0, 0, 32'h0,          1, 32'h8,          0, 32'h4);   // 3 wait states
    add(0, 0, 0, 0, 32'h0,          1, 32'h8,          0, 32'h4);
    add(0, 0, 0, 0, 32'h0,          1, 32'h8,          0, 32'h4);
    add(0, 1, 0, 0, 32'h0,          1, 32'hC,          1, 32'h8);
    add(0, 1, 1, 0, 32'h0,          0, 32'h10,         1, 32'h8);   // skid capture of 0xC
    add(0, 1, 1, 0, 32'h0,          0, 32'h10,         1, 32'h8);   // hold
    add(0, 1, 0, 0, 32'h0,          1, 32'h10,         1, 32'hC);   // drain buffer
    add(0, 1, 0, 0, 32'h0,          1, 32'h14,         1, 32'h10);
    add(0, 1, 1, 0, 32'h0,          0, 32'h18,         1, 32'h10);  // buffer 0x14
    add(0, 1, 1, 1, 32'h400,        1, 32'h400,        0, 32'h10);  // flush beats stall
    add(0, 1, 0, 0, 32'h0,          1, 32'h404,        1, 32'h400);
    add(0, 1, 0, 1, 32'h800,        1, 32'h800,        0, 32'h400); // response dropped
    add(0, 1, 0, 0, 32'h0,          1, 32'h804,        1, 32'h800);
    add(0, 1, 0, 1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC,  0, 32'h800);
    add(0, 1, 0, 0, 32'h0,          1, 32'h0,          1, 32'hFFFF_FFFC); // wrap
    add(0, 1, 0, 0, 32'h0,          1, 32'h4,          1, 32'h0);
    add(0, 1, 1, 0, 32'h0,          0, 32'h8,          1, 32'h0);   // enter S_HOLD
    add(1, 1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0);   // reset in S_HOLD
    add(0, 1, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
    add(0, 1, 0, 0, 32'h0,          1, 32'h4,          1, 32'h0);
    add(0, 1, 0, 1, 32'h203,        1, 32'h203,        0, 32'h0);   // unaligned target
    add(0, 1, 0, 0, 32'h0,          1, 32'h207,        1, 32'h203);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].rdy, vecs[i].stl, vecs[i].br, vecs[i].tgt);
      chk($sformatf("v%0d.req", i),   {31'h0, imem_req}, {31'h0, vecs[i].e_req});
      chk($sformatf("v%0d.addr", i),  imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d.valid", i), {31'h0, id_valid}, {31'h0, vecs[i].e_valid});
      chk($sformatf("v%0d.pc", i),    id_pc, vecs[i].e_pc);
      chk($sformatf("v%0d.instr", i), id_instr, vecs[i].e_instr);
    end

    // Long stall in S_HOLD with memory toggling: nothing may move.
    step(0, 1, 1, 0, 32'h0);
    chk_out("hold_in", 0, 32'h20B, 1, 32'h203);
    for (int k = 0; k < 4; k++) begin
      step(0, k[0], 1, 0, 32'h0);
      chk_out($sformatf("hold%0d", k), 0, 32'h20B, 1, 32'h203);
    end
    step(0, 1, 0, 0, 32'h0);
    chk_out("hold_out", 1, 32'h20B, 1, 32'h207);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0, 32'h0);
      chk_out($sformatf("stream%0d", k), 1, 32'h20F + 32'(4 * k), 1, 32'h20B + 32'(4 * k));
    end

    // Reset while a fetch is pending (no ready): no stale capture afterwards.
    step(0, 0, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    chk_out("rst_pend", 0, 32'h0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    chk_out("rst_boot", 1, 32'h0, 0, 32'h0);
    // Bounded wait for the first valid once memory answers.
    waited = 0;
    @(negedge clk);
    imem_ready = 1'b1;
    while (!id_valid && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("rst_first_wait", 32'(waited), 32'd1);
    chk_out("rst_first", 1, 32'h4, 1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
